// File: rtl/turn_signal_seq.sv
// turn_signal_seq: sweeping turn/hazard/brake lamp sequencer with internal tick divider (in: Clk, Reset, left, right, hazard, brake; out: out lamps, busy, mode)
module turn_signal_seq #(
  parameter int LAMPS = 3,
  parameter int TICK_DIV = 50000000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  input  logic               brake,
  output logic [2*LAMPS-1:0] out,
  output logic               busy,
  output logic [1:0]         mode
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(LAMPS + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, LSEQ = 2'b01, RSEQ = 2'b10, HAZ = 2'b11} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] step_q, step_d;
  logic [2*LAMPS-1:0] out_q, out_d;
  logic [LAMPS-1:0] grow, rgrow, fill;
  logic tick, haz_req, more;
  assign tick = div_q == DW'(TICK_DIV - 1);
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign haz_req = hazard | (left & right);
  assign more = step_q < SW'(LAMPS);
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    if (tick)
      case (state_q)
        IDLE: begin
          state_d = haz_req ? HAZ : left ? LSEQ : right ? RSEQ : IDLE;
          step_d = (!haz_req && (left || right)) ? SW'(1) : '0;
        end
        LSEQ, RSEQ: begin
          state_d = haz_req ? HAZ : more ? state_q : IDLE;
          step_d = (!haz_req && more) ? step_q + 1'b1 : '0;
        end
        default: begin
          state_d = IDLE;
          step_d = '0;
        end
      endcase
  end
  always_comb begin
    grow = '0;
    for (int i = 0; i < LAMPS; i++) grow[i] = SW'(i) < step_q;
  end
  assign rgrow = {<<{grow}};
  assign fill = {LAMPS{brake}};
  assign out_d = state_q == HAZ  ? '1 :
                 state_q == LSEQ ? {grow, fill} :
                 state_q == RSEQ ? {fill, rgrow} : {2*LAMPS{brake}};
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q <= '0;
      state_q <= IDLE;
      step_q <= '0;
      out_q <= '0;
    end else begin
      div_q <= div_d;
      state_q <= state_d;
      step_q <= step_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
  assign busy = state_q != IDLE;
  assign mode = state_q;
endmodule

// File: tb/tb_turn_signal_seq.sv
// tb_turn_signal_seq: randomized scoreboard bench for two turn_signal_seq configurations
module tb_turn_signal_seq;
  localparam int L0 = 3, T0 = 4, L1 = 4, T1 = 3;
  logic Clk = 0, Reset = 0, left = 0, right = 0, hazard = 0, brake = 0;
  logic [2*L0-1:0] out0;
  logic [2*L1-1:0] out1;
  logic busy0, busy1;
  logic [1:0] mode0, mode1;
  typedef struct packed {logic [7:0] out; logic busy; logic [1:0] mode;} exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int m_mode[2], m_step[2], n;
  int lamps[2] = '{L0, L1};
  int tdiv[2] = '{T0, T1};
  turn_signal_seq #(.LAMPS(L0), .TICK_DIV(T0)) dut0 (
    .Clk(Clk), .Reset(Reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .out(out0), .busy(busy0), .mode(mode0)
  );
  turn_signal_seq #(.LAMPS(L1), .TICK_DIV(T1)) dut1 (
    .Clk(Clk), .Reset(Reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .out(out1), .busy(busy1), .mode(mode1)
  );
  always #5 Clk = ~Clk;
  function automatic logic [7:0] pattern(int l, int md, int st, logic br);
    int all, half, lit;
    all = (1 << (2 * l)) - 1;
    half = (1 << l) - 1;
    lit = (1 << st) - 1;
    case (md)
      1: return 8'((lit << l) | (br ? half : 0));
      2: return 8'((br ? (half << l) : 0) | (lit << (l - st)));
      3: return 8'(all);
      default: return br ? 8'(all) : 8'(0);
    endcase
  endfunction
  task automatic push(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic reset_model();
    q0.delete();
    q1.delete();
    n = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0;
      m_step[k] = 0;
      push(k, '0);
    end
  endtask
  task automatic model_edge();
    exp_t e;
    logic haz;
    haz = hazard | (left & right);
    for (int k = 0; k < 2; k++) begin
      e.out = pattern(lamps[k], m_mode[k], m_step[k], brake);
      if (n % tdiv[k] == tdiv[k] - 1) begin
        case (m_mode[k])
          0: begin
            if (haz) m_mode[k] = 3;
            else if (left) begin m_mode[k] = 1; m_step[k] = 1; end
            else if (right) begin m_mode[k] = 2; m_step[k] = 1; end
          end
          1, 2: begin
            if (haz) m_mode[k] = 3;
            else if (m_step[k] < lamps[k]) m_step[k]++;
            else begin m_mode[k] = 0; m_step[k] = 0; end
          end
          default: begin m_mode[k] = 0; m_step[k] = 0; end
        endcase
      end
      e.busy = m_mode[k] != 0;
      e.mode = 2'(m_mode[k]);
      push(k, e);
    end
    n++;
  endtask
  task automatic check(string name, logic [7:0] o, logic b, logic [1:0] m, exp_t e);
    checks++;
    if (o !== e.out || b !== e.busy || m !== e.mode) begin
      errors++;
      $display("FAIL %s t=%0t got out=%b busy=%b mode=%b expected out=%b busy=%b mode=%b",
               name, $time, o, b, m, e.out, e.busy, e.mode);
    end
  endtask
  always @(negedge Clk) begin
    if (q0.size() > 0) check("dut0", {2'b00, out0}, busy0, mode0, q0.pop_front());
    if (q1.size() > 0) check("dut1", out1, busy1, mode1, q1.pop_front());
  end
  initial begin
    int hold, r;
    hold = 0;
    Reset = 1;
    reset_model();
    @(negedge Clk);
    #1 Reset = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge Clk);
      model_edge();
      if ($urandom_range(0, 249) == 0) begin
        #2 Reset = 1;
        reset_model();
        @(negedge Clk);
        #1 Reset = 0;
      end else begin
        @(negedge Clk);
        #1;
        if (hold == 0) begin
          r = $urandom_range(0, 9);
          left = r <= 3 || r == 7;
          right = (r >= 4 && r <= 7);
          hazard = r == 8;
          hold = $urandom_range(1, 20);
        end
        hold--;
        if ($urandom_range(0, 14) == 0) brake = ~brake;
      end
    end
    @(negedge Clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got q0=%0d q1=%0d expected 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/turn_signal_seq.md
Name: turn_signal_seq

Overview:
- Parametrised successor of the tail-light turn-indicator FSM. Drives LAMPS lamps per side with a sequential outward sweep for left and right turns.
- Adds a hazard flash mode and a brake overlay.
- Contains an internal tick divider, so the whole block runs on the single board clock with no derived clocks.
- Sits between the board switches/buttons and the LED bank.

Parameters:
- LAMPS, 3, number of lamps per side (>=1); out width is 2*LAMPS.
- TICK_DIV, 50000000, Clk cycles per sequence step (>=2); benches override it with a small value.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- left  input  1  left-turn request, level-sensitive.
- right  input  1  right-turn request, level-sensitive.
- hazard  input  1  hazard request, level-sensitive.
- brake  input  1  brake pedal, level-sensitive.
- out  output  2*LAMPS  lamp drives; out[2*LAMPS-1:LAMPS] is the left side, out[LAMPS-1:0] is the right side. Index LAMPS-1 and index LAMPS are the innermost lamps; out[2*LAMPS-1] and out[0] are the outermost.
- busy  output  1  high when the FSM state is not IDLE.
- mode  output  2  current state: 00 IDLE, 01 LSEQ, 10 RSEQ, 11 HAZ.

Behaviour:
- Reset is one clock and asynchronous, active-high. It clears the divider counter, state=IDLE, step=0, out=0, busy=0, mode=00. Asserting Reset mid-sequence aborts immediately with no completion.
- Divider: div_cnt counts 0..TICK_DIV-1 and wraps to 0. tick=1 (combinational) when div_cnt==TICK_DIV-1. The first tick after reset release is at the TICK_DIV-th rising edge. div_cnt width is $clog2(TICK_DIV).
- State and step change only on edges where tick=1. Between ticks, inputs are ignored except brake, which acts through the output logic.
- haz_req = hazard | (left & right).
- IDLE on tick:
  - haz_req -> HAZ.
  - else left -> LSEQ, step=1.
  - else right -> RSEQ, step=1.
  - else stay in IDLE.
- LSEQ/RSEQ on tick:
  - haz_req -> HAZ (abort).
  - else step<LAMPS -> step+1.
  - else (step==LAMPS) -> IDLE, step=0.
  - Changes to left/right mid-sequence are ignored; the sweep always completes.
- HAZ on tick -> IDLE. The IDLE phase is the hazard off-phase, so held hazard flashes with a 2-tick period.
- A held left request repeats with a period of LAMPS+1 ticks: 1..LAMPS lamps, then one all-off tick in IDLE. A request shorter than one tick is lost unless it is high on a tick edge.
- Lamp pattern, a function of state, step and brake:
  - LSEQ: the left side lights its innermost `step` lamps, growing outward. The right side is all on if brake=1, else off.
  - RSEQ: mirror image of LSEQ.
  - HAZ: all 2*LAMPS lamps on. Brake is ignored in HAZ.
  - IDLE: all on if brake=1, else all off.
- Output timing: out is registered and updated every Clk edge. out(t+1) = pattern(state(t), step(t), brake(t)), i.e. one Clk latency after a state change or brake change.
- busy and mode are direct decodes of the state register, with no extra latency.
- step width is $clog2(LAMPS+1). step never exceeds LAMPS. Unreachable state encodings return to IDLE on the next tick.

Test Plan (LAMPS=3, TICK_DIV=4; "per tick" = out sampled one Clk after each tick edge):
- Reset, all inputs 0, run 40 cycles -> out=000000, busy=0, mode=00 throughout. div_cnt wraps 0..3.
- left held -> per tick out = 001000, 011000, 111000, 000000, 001000, ...; mode = 01,01,01,00,01.
- right high for exactly one tick edge, then 0 -> 000100, 000110, 000111, 000000, then out stays 000000 and busy=0.
- left=right=1 (or hazard=1), then hazard asserted during LSEQ step 2 -> 111111, 000000 alternating. The abort case reads 011000 -> 111111 on the next tick.
- brake=1 in IDLE -> 111111 one Clk later. Then left held with brake -> 001111, 011111, 111111, 111111 (IDLE+brake). Brake released mid-step -> right half off after 1 Clk without waiting for a tick.
- Reset pulsed mid-LSEQ at step 2 -> out=000000 and mode=00 immediately. Left held afterwards -> the first lamp lights at the 4th edge+1 after release.
- Re-run the left-held scenario with LAMPS=4 -> 00010000, 00110000, 01110000, 11110000, 00000000.
